// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register sequencer: command codes, status bits,
// sequencer states and the per-step command/byte lookup.
package i2c_pkg;

   localparam logic [2:0] CMD_NONE       = 3'b000;
   localparam logic [2:0] CMD_START_ADDR = 3'b010;
   localparam logic [2:0] CMD_DATA       = 3'b100;
   localparam logic [2:0] CMD_DATA_STOP  = 3'b101;
   localparam logic [2:0] CMD_STOP       = 3'b001;

   localparam int unsigned ST_BUSY = 0;
   localparam int unsigned ST_NACK = 1;

   localparam int unsigned STEP_W = 2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_IDLE,
      S_CHECK,
      S_STOP_ISSUE,
      S_STOP_WAIT_BUSY,
      S_STOP_WAIT_IDLE,
      S_RESP
   } seq_state_e;

   typedef struct packed {
      logic       write;
      logic [6:0] dev_addr;
      logic [7:0] reg_addr;
      logic [7:0] wdata;
   } seq_req_t;

   // Writes: START/addr, reg, data+STOP. Reads add a repeated START before the final byte.
   function automatic logic [2:0] step_code(input logic write, input logic [STEP_W-1:0] step);
      case (step)
         2'd0:    return CMD_START_ADDR;
         2'd1:    return CMD_DATA;
         2'd2:    return write ? CMD_DATA_STOP : CMD_START_ADDR;
         default: return CMD_DATA_STOP;
      endcase
   endfunction

   function automatic logic [7:0] step_byte(input seq_req_t r, input logic [STEP_W-1:0] step);
      case (step)
         2'd0:    return {r.dev_addr, 1'b0};
         2'd1:    return r.reg_addr;
         2'd2:    return r.write ? r.wdata : {r.dev_addr, 1'b1};
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic is_last_step(input logic write, input logic [STEP_W-1:0] step);
      return write ? (step == STEP_W'(2)) : (step == STEP_W'(3));
   endfunction

endpackage

// File: rtl/i2c_reg_seq_if.sv
// Host request/response handshake plus the command/status link to the I2C control block.
interface i2c_reg_seq_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [6:0] req_dev_addr;
   logic [7:0] req_reg_addr;
   logic [7:0] req_wdata;

   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       rsp_timeout;

   logic [2:0] i2c_ctrl;
   logic [7:0] i2c_data;
   logic [3:0] i2c_status;
   logic [7:0] i2c_rdata;

   modport slave (
      input  req_valid, req_write, req_dev_addr, req_reg_addr, req_wdata,
      input  i2c_status, i2c_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
      output i2c_ctrl, i2c_data
   );

   modport master (
      output req_valid, req_write, req_dev_addr, req_reg_addr, req_wdata,
      output i2c_status, i2c_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
      input  i2c_ctrl, i2c_data
   );

endinterface

// File: rtl/i2c_step_timer.sv
// Per-step timeout counter: cleared at each command issue, counts while enabled,
// saturates and flags expiry once TIMEOUT_CYCLES cycles have elapsed.
module i2c_step_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && !expired_c) begin
         count_q <= count_q + TO_W'(1);
      end
   end

   assign expired_c = (count_q == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-level I2C sequencer: expands one read/write request into paced byte
// commands for the I2C control block and reports read data, nack or timeout.
module i2c_reg_seq
   import i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic          clk,
   input  logic          reset_n,
   i2c_reg_seq_if.slave  bus
);

   seq_state_e        state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   seq_req_t          req_q, req_d;

   logic       ready_q, ready_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rdata_q, rdata_d;
   logic       nack_q, nack_d;
   logic       timeout_q, timeout_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic [7:0] data_q, data_d;

   logic timer_clr_c, timer_en_c, timer_expired_c;
   logic busy_c, nack_in_c;
   logic status_unused_c;

   assign busy_c          = bus.i2c_status[ST_BUSY];
   assign nack_in_c       = bus.i2c_status[ST_NACK];
   assign status_unused_c = ^bus.i2c_status[3:2];

   i2c_step_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (timer_clr_c),
      .en        (timer_en_c),
      .expired_c (timer_expired_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         req_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         nack_q      <= 1'b0;
         timeout_q   <= 1'b0;
         ctrl_q      <= CMD_NONE;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         req_q       <= req_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         nack_q      <= nack_d;
         timeout_q   <= timeout_d;
         ctrl_q      <= ctrl_d;
         data_q      <= data_d;
      end
   end

   // Outputs are computed as next-cycle values so each one is a plain flop.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      req_d       = req_q;
      rdata_d     = rdata_q;
      nack_d      = nack_q;
      timeout_d   = timeout_q;
      ctrl_d      = CMD_NONE;
      data_d      = data_q;
      timer_clr_c = 1'b0;
      timer_en_c  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid && ready_q) begin
               req_d = '{write:    bus.req_write,
                         dev_addr: bus.req_dev_addr,
                         reg_addr: bus.req_reg_addr,
                         wdata:    bus.req_wdata};
               step_d    = '0;
               rdata_d   = '0;
               nack_d    = 1'b0;
               timeout_d = 1'b0;
               state_d   = S_ISSUE;
               ctrl_d    = step_code(req_d.write, step_d);
               data_d    = step_byte(req_d, step_d);
            end
         end
         S_ISSUE: begin
            timer_clr_c = 1'b1;
            state_d     = S_WAIT_BUSY;
         end
         S_WAIT_BUSY, S_WAIT_IDLE: begin
            timer_en_c = 1'b1;
            if (timer_expired_c) begin
               state_d   = S_RESP;
               timeout_d = 1'b1;
               nack_d    = 1'b0;
               rdata_d   = '0;
            end else if (state_q == S_WAIT_BUSY && busy_c) begin
               state_d = S_WAIT_IDLE;
            end else if (state_q == S_WAIT_IDLE && !busy_c) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            // The master nack on the final read byte is normal protocol, not an error.
            if (nack_in_c && (req_q.write || !is_last_step(req_q.write, step_q))) begin
               state_d = S_STOP_ISSUE;
               ctrl_d  = CMD_STOP;
            end else if (is_last_step(req_q.write, step_q)) begin
               state_d = S_RESP;
               if (!req_q.write) begin
                  rdata_d = bus.i2c_rdata;
               end
            end else begin
               step_d  = step_q + STEP_W'(1);
               state_d = S_ISSUE;
               ctrl_d  = step_code(req_q.write, step_d);
               data_d  = step_byte(req_q, step_d);
            end
         end
         S_STOP_ISSUE: begin
            timer_clr_c = 1'b1;
            state_d     = S_STOP_WAIT_BUSY;
         end
         S_STOP_WAIT_BUSY, S_STOP_WAIT_IDLE: begin
            timer_en_c = 1'b1;
            nack_d     = 1'b1;
            if (timer_expired_c) begin
               state_d   = S_RESP;
               timeout_d = 1'b1;
            end else if (state_q == S_STOP_WAIT_BUSY && busy_c) begin
               state_d = S_STOP_WAIT_IDLE;
            end else if (state_q == S_STOP_WAIT_IDLE && !busy_c) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d     = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
   end

   assign bus.req_ready   = ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_nack    = nack_q;
   assign bus.rsp_timeout = timeout_q;
   assign bus.i2c_ctrl    = ctrl_q;
   assign bus.i2c_data    = data_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: behavioural control-block model, directed requests,
// and a queue-based scoreboard checking commands and responses as they appear.
module tb_i2c_reg_seq;
   import i2c_pkg::*;

   localparam int unsigned TO_CYC = 50;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   i2c_reg_seq_if bus();

   i2c_reg_seq #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   logic [10:0] cmd_q[$];   // {ctrl, data}
   logic [9:0]  rsp_q[$];   // {rdata, nack, timeout}
   int rsp_count = 0;
   int last_rsp_cyc = 0;
   int last_cmd_cyc = 0;
   logic [10:0] mon_cmd_exp;
   logic [9:0]  mon_rsp_exp;

   // control-block model knobs and state
   int         busy_len = 40;
   bit         never_busy = 1'b0;
   int         nack_at = -1;
   logic [7:0] rdata_val = 8'h00;
   int         ncmd = 0;
   int         cur_idx = 0;
   int         mcnt = 0;
   logic       m_busy = 1'b0;
   logic       m_nack = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Control-block model: busy rises the cycle a command is seen, falls busy_len cycles later.
   initial begin
      bus.i2c_status = 4'h0;
      bus.i2c_rdata  = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_busy = 1'b0;
            m_nack = 1'b0;
            mcnt   = 0;
         end else if (bus.i2c_ctrl != 3'b000) begin
            m_busy  = !never_busy;
            m_nack  = 1'b0;
            mcnt    = busy_len;
            cur_idx = ncmd;
            ncmd++;
         end else if (m_busy) begin
            mcnt--;
            if (mcnt == 0) begin
               m_busy = 1'b0;
               m_nack = (cur_idx == nack_at);
               bus.i2c_rdata = rdata_val;
            end
         end
         bus.i2c_status = {2'b00, m_nack, m_busy};
      end
   end

   // Scoreboard monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (bus.i2c_ctrl != 3'b000) begin
               last_cmd_cyc = cyc;
               if (cmd_q.size() == 0) begin
                  check("unexpected_cmd", 32'({bus.i2c_ctrl, bus.i2c_data}), 32'd0);
               end else begin
                  mon_cmd_exp = cmd_q.pop_front();
                  check("cmd", 32'({bus.i2c_ctrl, bus.i2c_data}), 32'(mon_cmd_exp));
               end
            end
            if (bus.rsp_valid) begin
               last_rsp_cyc = cyc;
               rsp_count++;
               check("ready_in_resp", 32'(bus.req_ready), 32'd0);
               if (rsp_q.size() == 0) begin
                  check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
               end else begin
                  mon_rsp_exp = rsp_q.pop_front();
                  check("rsp", 32'({bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout}),
                        32'(mon_rsp_exp));
               end
            end
         end
      end
   end

   task automatic send(input logic w, input logic [6:0] d, input logic [7:0] r,
                       input logic [7:0] wd, input bit hold, output int acc_cyc);
      bus.req_write    = w;
      bus.req_dev_addr = d;
      bus.req_reg_addr = r;
      bus.req_wdata    = wd;
      bus.req_valid    = 1'b1;
      for (int n = 0; n < 3000 && !bus.req_ready; n++) @(negedge clk);
      if (!bus.req_ready) check("req_accept", 32'(bus.req_ready), 32'd1);
      acc_cyc = cyc;
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int n = 0; n < 3000 && rsp_count < target; n++) @(negedge clk);
      if (rsp_count < target) check("rsp_wait", 32'(rsp_count), 32'(target));
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_rsp"}, 32'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout}), 32'd0);
      check({tag, "_ctrl"}, 32'(bus.i2c_ctrl), 32'd0);
      check({tag, "_data"}, 32'(bus.i2c_data), 32'd0);
   endtask

   int acc, acc_b, base;

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_dev_addr = 7'h00;
      bus.req_reg_addr = 8'h00;
      bus.req_wdata    = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset_n = 1'b1;
      @(negedge clk);

      // Plain write
      cmd_q.push_back({CMD_START_ADDR, 8'hA0});
      cmd_q.push_back({CMD_DATA,       8'h10});
      cmd_q.push_back({CMD_DATA_STOP,  8'hA5});
      rsp_q.push_back({8'h00, 1'b0, 1'b0});
      send(1'b1, 7'h50, 8'h10, 8'hA5, 1'b0, acc);
      wait_rsp(1);
      check("wr_latency", 32'(last_rsp_cyc - acc), 32'd127);

      // Read with expected master nack on last byte
      nack_at   = ncmd + 3;
      rdata_val = 8'h3C;
      cmd_q.push_back({CMD_START_ADDR, 8'hA0});
      cmd_q.push_back({CMD_DATA,       8'h22});
      cmd_q.push_back({CMD_START_ADDR, 8'hA1});
      cmd_q.push_back({CMD_DATA_STOP,  8'h00});
      rsp_q.push_back({8'h3C, 1'b0, 1'b0});
      send(1'b0, 7'h50, 8'h22, 8'h00, 1'b0, acc);
      wait_rsp(2);

      // Address nack -> STOP only
      nack_at = ncmd;
      cmd_q.push_back({CMD_START_ADDR, 8'hA0});
      cmd_q.push_back({CMD_STOP,       8'hA0});
      rsp_q.push_back({8'h00, 1'b1, 1'b0});
      send(1'b1, 7'h50, 8'h10, 8'h77, 1'b0, acc);
      wait_rsp(3);

      // Nack on write data byte
      nack_at = ncmd + 2;
      cmd_q.push_back({CMD_START_ADDR, 8'h3A});
      cmd_q.push_back({CMD_DATA,       8'h80});
      cmd_q.push_back({CMD_DATA_STOP,  8'hC3});
      cmd_q.push_back({CMD_STOP,       8'hC3});
      rsp_q.push_back({8'h00, 1'b1, 1'b0});
      send(1'b1, 7'h1D, 8'h80, 8'hC3, 1'b0, acc);
      wait_rsp(4);
      nack_at = -1;

      // Busy never rises -> timeout
      never_busy = 1'b1;
      cmd_q.push_back({CMD_START_ADDR, 8'hA0});
      rsp_q.push_back({8'h00, 1'b0, 1'b1});
      send(1'b1, 7'h50, 8'h10, 8'hA5, 1'b0, acc);
      wait_rsp(5);
      check("to_latency", 32'(last_rsp_cyc - last_cmd_cyc), 32'd52);
      repeat (5) @(negedge clk);
      check("to_ctrl_idle", 32'(bus.i2c_ctrl), 32'd0);
      never_busy = 1'b0;

      // Reset in the middle of step 1 of a write
      base = ncmd;
      cmd_q.push_back({CMD_START_ADDR, 8'h54});
      cmd_q.push_back({CMD_DATA,       8'h01});
      send(1'b1, 7'h2A, 8'h01, 8'h5A, 1'b0, acc);
      for (int n = 0; n < 500 && ncmd < base + 2; n++) @(negedge clk);
      check("step1_reached", 32'(ncmd - base), 32'd2);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      check("mid_rst_cmds_left", 32'(cmd_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_count), 32'd5);

      // Same write after reset runs from step 0
      cmd_q.push_back({CMD_START_ADDR, 8'h54});
      cmd_q.push_back({CMD_DATA,       8'h01});
      cmd_q.push_back({CMD_DATA_STOP,  8'h5A});
      rsp_q.push_back({8'h00, 1'b0, 1'b0});
      send(1'b1, 7'h2A, 8'h01, 8'h5A, 1'b0, acc);
      wait_rsp(6);

      // Back-to-back with req_valid held across the first response
      base      = ncmd;
      nack_at   = base + 6;
      rdata_val = 8'h9E;
      cmd_q.push_back({CMD_START_ADDR, 8'h22});
      cmd_q.push_back({CMD_DATA,       8'h02});
      cmd_q.push_back({CMD_DATA_STOP,  8'h33});
      cmd_q.push_back({CMD_START_ADDR, 8'h22});
      cmd_q.push_back({CMD_DATA,       8'h04});
      cmd_q.push_back({CMD_START_ADDR, 8'h23});
      cmd_q.push_back({CMD_DATA_STOP,  8'h00});
      rsp_q.push_back({8'h00, 1'b0, 1'b0});
      rsp_q.push_back({8'h9E, 1'b0, 1'b0});
      send(1'b1, 7'h11, 8'h02, 8'h33, 1'b1, acc);
      send(1'b0, 7'h11, 8'h04, 8'h00, 1'b0, acc_b);
      check("b2b_accept_cycle", 32'(acc_b - last_rsp_cyc), 32'd1);
      wait_rsp(8);
      nack_at = -1;

      repeat (5) @(negedge clk);
      check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
      check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
